// File: rtl/ir_packet_scheduler.sv
// Bus-mapped scheduler for the IR transmitter: holds the CPU direction command and issues
// guarded SEND_PACKET triggers (periodic or one-shot), with a packet-count watchdog.
module ir_packet_scheduler #(
    parameter logic [7:0] BASE_ADDR     = 8'hB0,
    parameter int         PERIOD_CYCLES = 10_000_000,
    parameter int         GUARD_CYCLES  = 2_500_000,
    parameter int         WDOG_PACKETS  = 10
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_WDATA,
    input  logic       BUS_WE,
    input  logic       BUS_RE,
    output logic [7:0] BUS_RDATA,
    output logic       BUS_RVALID,
    output logic [3:0] COMMAND,
    output logic       SEND_PACKET,
    output logic       BUSY
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int WW = $clog2(WDOG_PACKETS + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_FULL   = WW'(WDOG_PACKETS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [3:0]    cmd;
    logic [3:0]    command_q;
    logic          auto_en;
    logic          wdog_en;
    logic          tripped;
    logic          pending;
    logic [PW-1:0] period_cnt;
    logic [GW-1:0] guard_cnt;
    logic [3:0]    pkt_cnt;
    logic [WW-1:0] wdog_cnt;

    logic sel_cmd, sel_ctrl, sel_status;
    logic wr_cmd, wr_ctrl;
    logic auto_next;
    logic period_wrap;
    logic new_req;
    logic req;
    logic guard_done;
    logic trip;
    logic unused_wdata;

    assign sel_cmd    = (BUS_ADDR == BASE_ADDR);
    assign sel_ctrl   = (BUS_ADDR == BASE_ADDR + 8'd1);
    assign sel_status = (BUS_ADDR == BASE_ADDR + 8'd2);
    assign wr_cmd     = BUS_WE & sel_cmd;
    assign wr_ctrl    = BUS_WE & sel_ctrl;
    assign unused_wdata = ^BUS_WDATA[7:4];

    // The period counter follows the AUTO value being written this cycle, so the
    // first auto trigger lands exactly PERIOD_CYCLES after the enabling write.
    assign auto_next   = wr_ctrl ? BUS_WDATA[0] : auto_en;
    assign period_wrap = auto_next && (period_cnt == PERIOD_LAST);
    assign new_req     = (wr_ctrl & BUS_WDATA[1]) | period_wrap;
    assign req         = pending | new_req;
    assign guard_done  = (guard_cnt == GUARD_LAST);

    // A CMD write in the same cycle as the trip takes priority.
    assign trip = wdog_en && (wdog_cnt == WDOG_FULL) && !wr_cmd;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = TRIG;
            TRIG:    state_next = HOLD;
            HOLD:    if (guard_done) state_next = req ? TRIG : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= IDLE;
        else         state <= state_next;
    end

    // COMMAND shows the live CMD during TRIG (pre-write value) and is frozen otherwise.
    assign SEND_PACKET = (state == TRIG);
    assign BUSY        = (state != IDLE);
    assign COMMAND     = (state == TRIG) ? cmd : command_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            command_q  <= 4'd0;
            pkt_cnt    <= 4'd0;
            pending    <= 1'b0;
            period_cnt <= '0;
            guard_cnt  <= '0;
        end else begin
            if (state == TRIG) begin
                command_q <= cmd;
                pkt_cnt   <= pkt_cnt + 4'd1;
            end
            // Entering TRIG consumes every outstanding request at once.
            pending <= (state_next == TRIG && state != TRIG) ? 1'b0 : (pending | new_req);
            if (!auto_next)       period_cnt <= '0;
            else if (period_wrap) period_cnt <= '0;
            else                  period_cnt <= period_cnt + 1'b1;
            if (state == HOLD && !guard_done) guard_cnt <= guard_cnt + 1'b1;
            else                              guard_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cmd      <= 4'd0;
            auto_en  <= 1'b0;
            wdog_en  <= 1'b0;
            tripped  <= 1'b0;
            wdog_cnt <= '0;
        end else begin
            if (wr_ctrl) begin
                auto_en <= BUS_WDATA[0];
                wdog_en <= BUS_WDATA[2];
            end
            if (wr_cmd) begin
                cmd     <= BUS_WDATA[3:0];
                tripped <= 1'b0;
            end else if (trip) begin
                cmd     <= 4'd0;
                tripped <= 1'b1;
            end
            if (wr_cmd || !wdog_en)
                wdog_cnt <= '0;
            else if (state == TRIG && wdog_cnt != WDOG_FULL)
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            BUS_RDATA  <= 8'd0;
            BUS_RVALID <= 1'b0;
        end else if (BUS_RE && (sel_cmd || sel_ctrl || sel_status)) begin
            BUS_RVALID <= 1'b1;
            if (sel_cmd)       BUS_RDATA <= {4'd0, cmd};
            else if (sel_ctrl) BUS_RDATA <= {5'd0, wdog_en, 1'b0, auto_en};
            else               BUS_RDATA <= {pkt_cnt, 1'b0, pending, tripped, BUSY};
        end else begin
            BUS_RVALID <= 1'b0;
        end
    end

endmodule
